// File: rtl/shift_operand_fetch.sv
// shift_operand_fetch: decodes a data-processing operand2, fetches Rm (and Rs) through a
// synchronous register-file read port and hands a registered bundle to the barrel shifter.
//
// state  | meaning
// IDLE   | ready for a request; immediate form is decoded straight into the bundle
// RD_RM  | rf_addr carries Rm
// RD_RS  | rf_addr carries Rs; Rm arrives on rf_data
// CAP    | last operand arrives on rf_data; bundle computed
// OUT    | bundle valid and frozen until out_ready
module shift_operand_fetch #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_imm,
  input  logic [11:0]   in_op2,
  output logic [3:0]    rf_addr,
  input  logic [DW-1:0] rf_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] sh_value,
  output logic [2:0]    sh_mode,
  output logic [4:0]    sh_count,
  output logic          sh_ge32
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_RM = 3'd1,
    S_RD_RS = 3'd2,
    S_CAP   = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  localparam logic [2:0] MODE_LSL  = 3'd0;
  localparam logic [2:0] MODE_ROR  = 3'd3;
  localparam logic [2:0] MODE_RRX  = 3'd4;
  localparam logic [2:0] MODE_PASS = 3'd5;

  state_t        state_q, state_d;
  logic [11:0]   op2_q, op2_d;
  logic [DW-1:0] rm_q, rm_d;
  logic [3:0]    addr_q, addr_d;
  logic [DW-1:0] value_q, value_d;
  logic [2:0]    mode_q, mode_d;
  logic [4:0]    count_q, count_d;
  logic          ge32_q, ge32_d;

  logic [4:0]    shift_imm;
  logic [1:0]    sh_type;
  logic [7:0]    rs_amt;
  logic [3:0]    imm_rot;

  assign shift_imm = op2_q[11:7];
  assign sh_type   = op2_q[6:5];
  assign rs_amt    = rf_data[7:0];
  assign imm_rot   = in_op2[11:8];

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = (state_q == S_OUT);
  assign rf_addr   = addr_q;
  assign sh_value  = value_q;
  assign sh_mode   = mode_q;
  assign sh_count  = count_q;
  assign sh_ge32   = ge32_q;

  always_comb begin
    state_d = state_q;
    op2_d   = op2_q;
    rm_d    = rm_q;
    addr_d  = addr_q;
    value_d = value_q;
    mode_d  = mode_q;
    count_d = count_q;
    ge32_d  = ge32_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op2_d = in_op2;
          if (in_imm) begin
            value_d = {{(DW-8){1'b0}}, in_op2[7:0]};
            count_d = {imm_rot, 1'b0};
            mode_d  = (imm_rot != 4'd0) ? MODE_ROR : MODE_PASS;
            ge32_d  = 1'b0;
            state_d = S_OUT;
          end else begin
            addr_d  = in_op2[3:0];
            state_d = S_RD_RM;
          end
        end
      end

      S_RD_RM: begin
        if (op2_q[4]) begin
          addr_d  = op2_q[11:8];
          state_d = S_RD_RS;
        end else begin
          state_d = S_CAP;
        end
      end

      S_RD_RS: begin
        rm_d    = rf_data;
        state_d = S_CAP;
      end

      S_CAP: begin
        state_d = S_OUT;
        ge32_d  = 1'b0;
        if (!op2_q[4]) begin
          // Immediate-shift: a zero amount means 32 for LSR/ASR and RRX for ROR.
          value_d = rf_data;
          count_d = shift_imm;
          case (sh_type)
            2'b00:        mode_d = MODE_LSL;
            2'b01, 2'b10: begin
              mode_d = {1'b0, sh_type};
              ge32_d = (shift_imm == 5'd0);
            end
            default:      mode_d = (shift_imm == 5'd0) ? MODE_RRX : MODE_ROR;
          endcase
        end else begin
          value_d = rm_q;
          if (rs_amt == 8'd0) begin
            mode_d  = MODE_PASS;
            count_d = 5'd0;
          end else begin
            mode_d  = {1'b0, sh_type};
            count_d = rs_amt[4:0];
            ge32_d  = (rs_amt >= 8'd32) && (sh_type != 2'b11);
          end
        end
      end

      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op2_q   <= '0;
      rm_q    <= '0;
      addr_q  <= '0;
      value_q <= '0;
      mode_q  <= MODE_PASS;
      count_q <= '0;
      ge32_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op2_q   <= op2_d;
      rm_q    <= rm_d;
      addr_q  <= addr_d;
      value_q <= value_d;
      mode_q  <= mode_d;
      count_q <= count_d;
      ge32_q  <= ge32_d;
    end
  end

endmodule

// File: tb/tb_shift_operand_fetch.sv
// Bench for shift_operand_fetch: directed test-plan steps followed by random requests,
// each checked against an arithmetic model of the operand2 decode rules.
module tb_shift_operand_fetch;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_imm = 1'b0;
  logic [11:0]   in_op2 = '0;
  logic          out_ready = 1'b0;
  logic          in_ready, out_valid, sh_ge32;
  logic [3:0]    rf_addr;
  logic [DW-1:0] rf_data, sh_value;
  logic [2:0]    sh_mode;
  logic [4:0]    sh_count;

  logic [DW-1:0] regs [16];
  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] value;
    logic [2:0]  mode;
    logic [4:0]  count;
    logic        ge32;
    logic [3:0]  lat;
  } exp_t;

  always #5 clk = ~clk;

  // Synchronous-read register file: address sampled at the edge, data the cycle after.
  always @(posedge clk) rf_data <= regs[rf_addr];

  shift_operand_fetch #(.DW(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_imm(in_imm), .in_op2(in_op2), .rf_addr(rf_addr), .rf_data(rf_data),
    .out_valid(out_valid), .out_ready(out_ready), .sh_value(sh_value),
    .sh_mode(sh_mode), .sh_count(sh_count), .sh_ge32(sh_ge32)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic imm, input logic [11:0] op2);
    exp_t e;
    int rot, si, ty, amt;
    e  = '0;
    ty = int'(op2[6:5]);
    if (imm) begin
      rot     = int'(op2[11:8]);
      e.value = 32'(int'(op2) % 256);
      e.count = 5'(rot * 2);
      e.mode  = (rot != 0) ? 3'd3 : 3'd5;
      e.lat   = 4'd1;
    end else begin
      e.value = regs[op2[3:0]];
      if (op2[4] == 1'b0) begin
        e.lat   = 4'd3;
        si      = int'(op2[11:7]);
        e.count = 5'(si);
        if (ty == 0)      e.mode = 3'd0;
        else if (ty == 3) e.mode = (si == 0) ? 3'd4 : 3'd3;
        else begin
          e.mode = 3'(ty);
          e.ge32 = (si == 0);
        end
      end else begin
        e.lat = 4'd4;
        amt   = int'(regs[op2[11:8]] % 256);
        if (amt == 0) e.mode = 3'd5;
        else begin
          e.mode  = 3'(ty);
          e.count = 5'(amt % 32);
          e.ge32  = (amt >= 32) && (ty != 3);
        end
      end
    end
    return e;
  endfunction

  task automatic check_bundle(input string tag, input exp_t e);
    check({tag, ".value"}, sh_value, e.value);
    check({tag, ".mode"},  sh_mode,  e.mode);
    check({tag, ".count"}, sh_count, e.count);
    check({tag, ".ge32"},  sh_ge32,  e.ge32);
  endtask

  // Issue one request at a negedge; optionally hold a second request on in_valid while stalled.
  task automatic run_req(input logic imm, input logic [11:0] op2, input int stall,
                         input logic bp, input logic [11:0] bp_op2, output int waited);
    exp_t e;
    int n;
    e = model(imm, op2);
    in_valid = 1'b1; in_imm = imm; in_op2 = op2; out_ready = 1'b0;
    waited = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("accept_ready", in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 12) begin
      @(negedge clk);
      n++;
    end
    check("latency", n, e.lat);
    check_bundle("bundle", e);
    if (bp) begin
      in_valid = 1'b1; in_imm = 1'b1; in_op2 = bp_op2;
    end
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1'b1);
      check("hold_in_ready", in_ready, 1'b0);
      check_bundle("hold", e);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("drop_valid", out_valid, 1'b0);
    check("idle_ready", in_ready, 1'b1);
  endtask

  function automatic logic [31:0] pick_reg();
    case ($urandom % 4)
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 31));
      2:       return 32'($urandom_range(32, 300));
      default: return 32'h0;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, seen;
    for (int i = 0; i < 16; i++) regs[i] = $urandom;
    regs[2] = 32'hfffffffe;

    // Power-on reset
    repeat (3) @(negedge clk);
    check("rst.out_valid", out_valid, 1'b0);
    check("rst.in_ready", in_ready, 1'b0);
    check("rst.mode", sh_mode, 3'd5);
    check("rst.count", sh_count, 5'd0);
    check("rst.value", sh_value, 32'h0);
    check("rst.ge32", sh_ge32, 1'b0);
    check("rst.rf_addr", rf_addr, 4'd0);
    rst = 1'b0;
    #1;
    check("rst.in_ready_after", in_ready, 1'b1);

    // Immediate forms, with explicit constants for the first one
    run_req(1'b1, 12'h2FF, 0, 1'b0, 12'h0, w);
    run_req(1'b1, 12'h0AB, 0, 1'b0, 12'h0, w);
    in_valid = 1'b1; in_imm = 1'b1; in_op2 = 12'h2FF;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    check("imm2FF.valid", out_valid, 1'b1);
    check("imm2FF.value", sh_value, 32'h000000FF);
    check("imm2FF.mode", sh_mode, 3'd3);
    check("imm2FF.count", sh_count, 5'd4);
    // Reset during OUT with out_ready low, held two cycles
    rst = 1'b1;
    @(negedge clk);
    check("rstout.out_valid", out_valid, 1'b0);
    check("rstout.in_ready", in_ready, 1'b0);
    check("rstout.mode", sh_mode, 3'd5);
    check("rstout.count", sh_count, 5'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstout.in_ready_next", in_ready, 1'b1);

    // Immediate-shift forms
    run_req(1'b0, 12'h222, 0, 1'b0, 12'h0, w);
    run_req(1'b0, 12'h042, 0, 1'b0, 12'h0, w);
    run_req(1'b0, 12'h062, 0, 1'b0, 12'h0, w);

    // Register-shift forms
    regs[3] = 32'd4;    run_req(1'b0, 12'h312, 0, 1'b0, 12'h0, w);
    regs[3] = 32'd40;   run_req(1'b0, 12'h312, 0, 1'b0, 12'h0, w);
    run_req(1'b0, 12'h372, 0, 1'b0, 12'h0, w);
    regs[3] = 32'h100;  run_req(1'b0, 12'h312, 0, 1'b0, 12'h0, w);

    // Backpressure with a second request waiting on in_valid
    regs[3] = 32'd40;
    run_req(1'b0, 12'h372, 5, 1'b1, 12'h1C3, w);
    run_req(1'b1, 12'h1C3, 0, 1'b0, 12'h0, w);
    check("bp.accept_wait", w, 0);

    // Reset while in RD_RS
    in_valid = 1'b1; in_imm = 1'b0; in_op2 = 12'h312;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst.in_ready", in_ready, 1'b1);
    seen = out_valid ? 1 : 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check("midrst.no_valid", seen, 0);
    run_req(1'b1, 12'h5A7, 0, 1'b0, 12'h0, w);

    // Random requests with random register contents and backpressure
    for (int i = 0; i < 60; i++) begin
      regs[$urandom % 16] = pick_reg();
      regs[$urandom % 16] = pick_reg();
      run_req(($urandom % 3) == 0, 12'($urandom), int'($urandom % 3), 1'b0, 12'h0, w);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/shift_operand_fetch.md
Name: shift_operand_fetch

Overview:
- Upstream feeder for the barrelshifter datapath stage.
- Accepts a data-processing operand2 field and decodes it.
- Reads Rm, and Rs when needed, through one synchronous register-file read port.
- Presents a registered {value, mode, count, ge32} bundle to the shifter over a valid/ready handshake.

Parameters:
- DW, 32, data width of register values and shifter operand.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operand2 request valid.
- in_ready  output  1  block can accept a request (IDLE only).
- in_imm  input  1  I bit: 1 = rotated immediate, 0 = register form.
- in_op2  input  12  operand2 field [11:0].
- rf_addr  output  4  register-file read address; sampled by the RF at the clock edge.
- rf_data  input  DW  RF read data; valid the cycle after rf_addr is presented.
- out_valid  output  1  shifter bundle valid.
- out_ready  input  1  shifter/ALU consumes the bundle.
- sh_value  output  DW  shifter input value.
- sh_mode  output  3  shift mode: 0 LSL, 1 LSR, 2 ASR, 3 ROR, 4 RRX, 5 pass.
- sh_count  output  5  shift amount.
- sh_ge32  output  1  amount is 32 or more (LSL/LSR/ASR only); downstream saturates.

Behaviour:
- Reset:
  - State goes to IDLE.
  - out_valid=0, sh_value=0, sh_mode=5, sh_count=0, sh_ge32=0, rf_addr=0.
  - in_ready=0 while rst is high and 1 the cycle after.
  - rst aborts any state and drops a pending output.
- States: IDLE, RD_RM, RD_RS, CAP, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid, latch in_imm and in_op2.
  - If in_imm=1, go to OUT. If in_imm=0, go to RD_RM.
- Immediate path (decoded on the accept edge):
  - sh_value = zero-extended op2[7:0].
  - sh_count = {op2[11:8],1'b0}.
  - sh_mode = 3 if op2[11:8]!=0, else 5.
  - sh_ge32=0.
- RD_RM:
  - rf_addr=op2[3:0].
  - Next state: RD_RS if op2[4]=1, else CAP.
- RD_RS:
  - rf_addr=op2[11:8].
  - Capture rf_data as Rm.
  - Next state: CAP.
- CAP:
  - Capture rf_data: this is Rm for the immediate-shift form, Rs for the register-shift form.
  - Compute the bundle.
  - Next state: OUT.
- Immediate-shift form (op2[4]=0); shift_imm = op2[11:7], type = op2[6:5]:
  - type 00: mode 0, count shift_imm.
  - type 01 or 10: mode 1 or 2. If shift_imm=0, count 0 and ge32=1; otherwise count shift_imm and ge32=0.
  - type 11: if shift_imm=0, mode 4, count 0; otherwise mode 3, count shift_imm.
- Register-shift form (op2[4]=1); amt = Rs[7:0]:
  - amt=0: mode 5, count 0, ge32 0.
  - Otherwise mode = type (0..3) and count = amt[4:0].
  - ge32 = (amt>=32) && type!=3. ROR uses amt mod 32 only.
- sh_value equals Rm for both register forms.
- OUT:
  - out_valid=1.
  - All sh_* outputs are held stable while out_ready=0.
  - On out_ready=1, go to IDLE and drop out_valid on the next cycle.
- Latency from the accept edge to out_valid high:
  - Immediate: 1 cycle.
  - Immediate-shift: 3 cycles.
  - Register-shift: 4 cycles.
- Throughput: one request per (latency + 1) cycles minimum. No new accept while not in IDLE.
- in_valid asserted outside IDLE is ignored and no request is lost. The requester must hold in_valid until in_ready.
- rf_addr outside RD_RM/RD_RS holds its last value; the RF ignores it.

Test Plan:
- Reset: hold rst 2 cycles during OUT with out_ready=0 -> out_valid=0 and in_ready=0 in the first cycle after the rst edge; in_ready=1 on the next cycle; sh_mode=5, sh_count=0.
- Immediate: in_imm=1, op2=12'h2FF -> after 1 cycle: out_valid=1, sh_value=32'h000000FF, mode=3, count=4. Op2=12'h0AB -> sh_value=32'h000000AB, mode=5, count=0.
- Immediate-shift: R2=32'hfffffffe, op2=12'h222 (LSR #4, Rm=2) -> after 3 cycles: value=32'hfffffffe, mode=1, count=4, ge32=0. Op2=12'h042 (ASR #0) -> mode=2, count=0, ge32=1. Op2=12'h062 -> mode=4.
- Register-shift: R2=32'hfffffffe.
  - R3=4, op2=12'h312 (LSL Rs) -> after 4 cycles: mode=0, count=4.
  - R3=40 -> count=8, ge32=1.
  - R3=40 with op2=12'h372 (ROR Rs) -> mode=3, count=8, ge32=0.
  - R3=32'h100 -> mode=5, count=0.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> bundle stable, in_ready=0, no second accept. Release out_ready -> IDLE; the next request is accepted one cycle later.
- Reset mid-fetch: assert rst in RD_RS -> next cycle IDLE, out_valid never rises, a subsequent immediate request completes normally.
